// File: rtl/lcd_stream_pkg.sv
// Shared definitions for the 17-bit tagged LCD frame stream.
// The stream writers and the reader all use these command words.
package lcd_stream_pkg;

    localparam int WORD_W = 17;

    localparam logic [WORD_W-1:0] CMD_FRAME_START = 17'h10000;
    localparam logic [WORD_W-1:0] CMD_ROW_START   = 17'h10001;
    localparam logic [WORD_W-1:0] CMD_FRAME_END   = 17'h1FFFF;

    localparam int SKID_DEPTH = 3;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        WAIT_ROW,
        ROW_PIXELS,
        WAIT_END
    } parser_state_e;

    function automatic logic [1:0] skid_ptr_next(input logic [1:0] ptr);
        return (ptr == 2'(SKID_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/pixel_skid_fifo.sv
// Three-entry skid buffer between the stream parser and the line-buffer side.
// Exposes the next-cycle occupancy so the reader can decide its pop one cycle ahead.
module pixel_skid_fifo
    import lcd_stream_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pushValid_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             popReady_i,
    output logic [WIDTH-1:0] headData_o,
    output logic             headValid_o,
    output logic [1:0]       countNext_o
);

    logic [WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [1:0]       wrPtr_q;
    logic [1:0]       rdPtr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             doPush;
    logic             doPop;

    assign doPop  = popReady_i && (count_q != 2'd0);
    assign doPush = pushValid_i && ((count_q != 2'(SKID_DEPTH)) || doPop);

    always_comb begin
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + 2'd1;
        end else if (!doPush && doPop) begin
            count_d = count_q - 2'd1;
        end
    end

    // Storage is cleared on reset so the pixel outputs read as zero until the first push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= pushData_i;
                wrPtr_q        <= skid_ptr_next(wrPtr_q);
            end
            if (doPop) begin
                rdPtr_q <= skid_ptr_next(rdPtr_q);
            end
            count_q <= count_d;
        end
    end

    assign headData_o  = mem_q[rdPtr_q];
    assign headValid_o = (count_q != 2'd0);
    assign countNext_o = count_d;

endmodule

// File: rtl/lcd_stream_reader.sv
// Consumer of the tagged LCD frame stream: pops the queue, checks frame geometry
// and hands annotated pixels to the line buffer; violations resync at the next frame start.
module lcd_stream_reader
    import lcd_stream_pkg::*;
#(
    parameter  int FRAME_WIDTH  = 480,
    parameter  int FRAME_HEIGHT = 272,
    localparam int XW           = $clog2(FRAME_WIDTH),
    localparam int YW           = $clog2(FRAME_HEIGHT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] queue_data,
    input  logic              queue_empty,
    output logic              queue_rd_en,
    output logic [15:0]       pix_data,
    output logic [XW-1:0]     pix_x,
    output logic [YW-1:0]     pix_y,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              frame_done,
    output logic              proto_err,
    output logic [7:0]        err_count
);

    localparam int PW = 16 + XW + YW + 3;

    parser_state_e state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          inFlight_q;
    logic          rdEn_q, rdEn_d;
    logic          frameDone_q, frameDone_d;
    logic          protoErr_q, protoErr_d;
    logic [7:0]    errCount_q;

    logic          popFire;
    logic          pushValid;
    logic [PW-1:0] pushData;
    logic [PW-1:0] headData;
    logic [1:0]    countNext;
    logic [2:0]    occupancyNext;
    logic          isPixel, isFrameStart, isRowStart, isFrameEnd;
    logic          lastCol, lastRow;

    assign isPixel      = !queue_data[16];
    assign isFrameStart = (queue_data == CMD_FRAME_START);
    assign isRowStart   = (queue_data == CMD_ROW_START);
    assign isFrameEnd   = (queue_data == CMD_FRAME_END);
    assign lastCol      = (x_q == XW'(FRAME_WIDTH - 1));
    assign lastRow      = (y_q == YW'(FRAME_HEIGHT - 1));

    // A pop commits a buffer slot a cycle ahead, so the next read enable is judged
    // on next-cycle occupancy plus the word that will then be in flight.
    assign popFire       = rdEn_q && !queue_empty;
    assign occupancyNext = {1'b0, countNext} + {2'b00, popFire};
    assign rdEn_d        = (occupancyNext < 3'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_FRAME;
            x_q         <= '0;
            y_q         <= '0;
            inFlight_q  <= 1'b0;
            rdEn_q      <= 1'b0;
            frameDone_q <= 1'b0;
            protoErr_q  <= 1'b0;
            errCount_q  <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            inFlight_q  <= popFire;
            rdEn_q      <= rdEn_d;
            frameDone_q <= frameDone_d;
            protoErr_q  <= protoErr_d;
            if (protoErr_d && (errCount_q != 8'hFF)) begin
                errCount_q <= errCount_q + 8'd1;
            end
        end
    end

    // A frame start always restarts the frame; outside WAIT_FRAME it is also flagged below.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        if (inFlight_q) begin
            if (isFrameStart) begin
                state_d = WAIT_ROW;
                y_d     = '0;
            end else begin
                case (state_q)
                    WAIT_ROW: begin
                        if (isRowStart) begin
                            state_d = ROW_PIXELS;
                            x_d     = '0;
                        end else begin
                            state_d = WAIT_FRAME;
                        end
                    end
                    ROW_PIXELS: begin
                        if (!isPixel) begin
                            state_d = WAIT_FRAME;
                        end else if (lastCol) begin
                            if (lastRow) begin
                                state_d = WAIT_END;
                            end else begin
                                state_d = WAIT_ROW;
                                y_d     = y_q + YW'(1);
                            end
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                    end
                    WAIT_END: state_d = WAIT_FRAME;
                    default:  state_d = state_q;
                endcase
            end
        end
    end

    always_comb begin
        pushValid   = 1'b0;
        frameDone_d = 1'b0;
        protoErr_d  = 1'b0;
        if (inFlight_q) begin
            case (state_q)
                WAIT_ROW:   protoErr_d = !isRowStart;
                ROW_PIXELS: begin
                    pushValid  = isPixel;
                    protoErr_d = !isPixel;
                end
                WAIT_END: begin
                    frameDone_d = isFrameEnd;
                    protoErr_d  = !isFrameEnd;
                end
                default: begin
                    pushValid = 1'b0;
                end
            endcase
        end
    end

    assign pushData = {queue_data[15:0], x_q, y_q,
                       (x_q == '0) && (y_q == '0), lastCol, lastCol && lastRow};

    pixel_skid_fifo #(
        .WIDTH (PW)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .pushValid_i (pushValid),
        .pushData_i  (pushData),
        .popReady_i  (pix_ready),
        .headData_o  (headData),
        .headValid_o (pix_valid),
        .countNext_o (countNext)
    );

    assign {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof} = headData;
    assign queue_rd_en = rdEn_q;
    assign frame_done  = frameDone_q;
    assign proto_err   = protoErr_q;
    assign err_count   = errCount_q;

endmodule

// File: tb/tb_lcd_stream_reader.sv
// Randomised scoreboard bench for lcd_stream_reader on a reduced 8x4 frame.
// A word-level reference model predicts pixels, frame ends and violations.
module tb_lcd_stream_reader;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int XW   = $clog2(W);
    localparam int YW   = $clog2(H);

    localparam logic [16:0] FS  = 17'h10000;
    localparam logic [16:0] RS  = 17'h10001;
    localparam logic [16:0] FE  = 17'h1FFFF;
    localparam logic [16:0] BAD = 17'h10005;

    logic          clk;
    logic          reset;
    logic [16:0]   queue_data;
    logic          queue_empty;
    logic          queue_rd_en;
    logic [15:0]   pix_data;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_sof, pix_eol, pix_eof, pix_valid, pix_ready;
    logic          frame_done, proto_err;
    logic [7:0]    err_count;

    lcd_stream_reader #(
        .FRAME_WIDTH  (W),
        .FRAME_HEIGHT (H)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .queue_data  (queue_data),
        .queue_empty (queue_empty),
        .queue_rd_en (queue_rd_en),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_sof     (pix_sof),
        .pix_eol     (pix_eol),
        .pix_eof     (pix_eof),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .frame_done  (frame_done),
        .proto_err   (proto_err),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    int compared   = 0;
    int mismatched = 0;

    logic [16:0] srcQ[$];
    logic [34:0] sbQ[$];
    int  readyMode   = 1;
    bit  stallMode   = 0;
    bit  measureSpan = 0;
    int  doneSeen    = 0;
    int  errSeen     = 0;

    bit  mInFrame = 0;
    bit  mRowOpen = 0;
    int  mPix     = 0;
    int  mDone    = 0;
    int  mErr     = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [34:0] packPix(input logic [15:0] d, input int x, input int y,
                                            input bit sof, input bit eol, input bit eof);
        return {d, 8'(x), 8'(y), sof, eol, eof};
    endfunction

    // Reference: a frame is NPIX pixels; each row of W is preceded by a row start,
    // the frame is bracketed by start/end commands, and any deviation abandons the frame.
    task automatic modelWord(input logic [16:0] w);
        int x, y;
        if (w == FS) begin
            if (mInFrame) mErr++;
            mInFrame = 1;
            mPix     = 0;
            mRowOpen = 0;
        end else if (!mInFrame) begin
            mInFrame = 0;
        end else if (mPix == NPIX) begin
            if (w == FE) mDone++;
            else mErr++;
            mInFrame = 0;
        end else if (!mRowOpen) begin
            if (w == RS) mRowOpen = 1;
            else begin
                mErr++;
                mInFrame = 0;
            end
        end else if (w[16]) begin
            mErr++;
            mInFrame = 0;
        end else begin
            x = mPix % W;
            y = mPix / W;
            sbQ.push_back(packPix(w[15:0], x, y, mPix == 0, x == W - 1, mPix == NPIX - 1));
            mPix++;
            if (mPix % W == 0) mRowOpen = 0;
        end
    endtask

    task automatic applyStimulus(input logic [16:0] w);
        srcQ.push_back(w);
        modelWord(w);
    endtask

    task automatic sendPixel();
        applyStimulus({1'b0, 16'($urandom)});
    endtask

    task automatic sendRow();
        applyStimulus(RS);
        repeat (W) sendPixel();
    endtask

    task automatic sendCleanFrame();
        applyStimulus(FS);
        repeat (H) sendRow();
        applyStimulus(FE);
    endtask

    // Behaviour of the dual-clock queue read side: pop decided on the registered
    // read enable, data presented the following cycle, junk otherwise.
    initial begin
        bit          doPop;
        logic [16:0] popWord;
        queue_empty = 1'b1;
        queue_data  = '0;
        popWord     = '0;
        forever begin
            @(negedge clk);
            doPop = !reset && queue_rd_en && !queue_empty && (srcQ.size() != 0);
            if (doPop) popWord = srcQ.pop_front();
            @(posedge clk);
            #1;
            queue_data  = doPop ? popWord : 17'($urandom);
            queue_empty = (srcQ.size() == 0) || (stallMode && ($urandom_range(3) == 0));
        end
    end

    initial begin
        pix_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                1:       pix_ready = 1'b1;
                2:       pix_ready = 1'($urandom_range(1));
                default: pix_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted pixel and checks stall stability.
    initial begin
        bit          prevStalled = 0;
        logic [35:0] prevWord    = '0;
        logic [34:0] act;
        logic [34:0] exp;
        int          sofCycle    = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prevStalled = 0;
            end else begin
                act = {pix_data, 8'(pix_x), 8'(pix_y), pix_sof, pix_eol, pix_eof};
                if (prevStalled) checkOutput("stall hold", {pix_valid, act}, prevWord);
                if (pix_valid && pix_ready) begin
                    if (sbQ.size() == 0) begin
                        checkOutput("unexpected pixel", act, 64'hDEAD);
                    end else begin
                        exp = sbQ.pop_front();
                        checkOutput("pixel", act, exp);
                    end
                    if (pix_sof) sofCycle = cycleCnt;
                    if (pix_eof && measureSpan)
                        checkOutput("frame span cycles", cycleCnt - sofCycle, NPIX - 1 + (H - 1));
                end
                prevStalled = pix_valid && !pix_ready;
                prevWord    = {1'b1, act};
                if (frame_done) doneSeen++;
                if (proto_err) errSeen++;
            end
        end
    end

    task automatic waitDrain();
        int n = 0;
        while ((srcQ.size() != 0 || sbQ.size() != 0) && n < 4000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 4000) checkOutput("drain timeout", 64'(sbQ.size() + srcQ.size()), 0);
        repeat (8) @(posedge clk);
    endtask

    task automatic checkCounters(input string phase);
        checkOutput({phase, " frame_done pulses"}, doneSeen, mDone);
        checkOutput({phase, " proto_err pulses"}, errSeen, mErr);
        checkOutput({phase, " err_count"}, err_count, (mErr > 255) ? 255 : mErr);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset rd_en/valid", {queue_rd_en, pix_valid}, 0);
        checkOutput("reset pixel outputs", {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof}, 0);
        checkOutput("reset pulses/count", {frame_done, proto_err, err_count}, 0);
        @(posedge clk);
        #2 reset = 1'b0;

        $display("[TB] clean frame at full rate");
        readyMode   = 1;
        measureSpan = 1;
        sendCleanFrame();
        waitDrain();
        measureSpan = 0;
        checkCounters("clean");

        $display("[TB] backpressure with queue stalls");
        readyMode = 2;
        stallMode = 1;
        repeat (3) sendCleanFrame();
        waitDrain();
        checkCounters("backpressure");

        $display("[TB] short row then clean frame");
        applyStimulus(FS);
        applyStimulus(RS);
        repeat (3) sendPixel();
        applyStimulus(RS);
        repeat (5) sendPixel();
        applyStimulus(FE);
        sendCleanFrame();
        waitDrain();
        checkCounters("short row");

        $display("[TB] stray words and illegal command");
        repeat (3) sendPixel();
        applyStimulus(FE);
        applyStimulus(FS);
        applyStimulus(BAD);
        sendCleanFrame();
        waitDrain();
        checkCounters("illegal cmd");

        $display("[TB] frame start in the middle of a frame");
        applyStimulus(FS);
        repeat (2) sendRow();
        applyStimulus(RS);
        repeat (3) sendPixel();
        sendCleanFrame();
        waitDrain();
        checkCounters("mid-frame start");

        $display("[TB] random mix of segments");
        for (int s = 0; s < 10; s++) begin
            case ($urandom_range(4))
                0: sendCleanFrame();
                1: begin
                    applyStimulus(FS);
                    repeat ($urandom_range(H - 1)) sendRow();
                    applyStimulus(RS);
                    repeat ($urandom_range(W - 1)) sendPixel();
                end
                2: repeat ($urandom_range(1, 4)) applyStimulus({1'b1, 16'($urandom)});
                3: repeat ($urandom_range(1, 5)) sendPixel();
                default: begin
                    applyStimulus(FS);
                    repeat (H) sendRow();
                    applyStimulus(RS);
                end
            endcase
        end
        sendCleanFrame();
        waitDrain();
        checkCounters("random");

        $display("[TB] error counter saturation");
        readyMode = 1;
        stallMode = 0;
        repeat (260) begin
            applyStimulus(FS);
            applyStimulus(BAD);
        end
        waitDrain();
        checkCounters("saturation");

        $display("[TB] reset in the middle of a stalled row");
        readyMode = 0;
        sendCleanFrame();
        repeat (25) @(posedge clk);
        #1;
        checkOutput("stalled before reset", pix_valid, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid reset rd_en/valid", {queue_rd_en, pix_valid}, 0);
        checkOutput("mid reset pixel outputs", {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof}, 0);
        checkOutput("mid reset pulses/count", {frame_done, proto_err, err_count}, 0);
        repeat (2) @(posedge clk);
        srcQ.delete();
        sbQ.delete();
        mInFrame = 0;
        mRowOpen = 0;
        mPix     = 0;
        mDone    = 0;
        mErr     = 0;
        doneSeen = 0;
        errSeen  = 0;
        @(posedge clk);
        #2 reset = 1'b0;
        readyMode = 1;
        sendCleanFrame();
        waitDrain();
        checkCounters("after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lcd_stream_reader.md
# lcd_stream_reader

Consumer end of the 17-bit tagged LCD frame stream: pops words from the dual-clock LCD queue (read side), parses frame/row command words, checks geometry, and delivers annotated pixels to the LCD line-buffer side over a valid/ready handshake. It is the hardware counterpart of the debug-pattern and camera writers, and runs on the LCD-side clock. Protocol violations are flagged, counted and resynchronised at the next frame start.

## Interface
- FRAME_WIDTH, 480, pixels per row
- FRAME_HEIGHT, 272, rows per frame
- clk  in  1  LCD-side clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- queue_data  in  17  queue Q; valid the cycle after a pop
- queue_empty  in  1  queue Empty
- queue_rd_en  out  1  queue RdEn; a pop occurs when queue_rd_en && !queue_empty
- pix_data  out  16  RGB565 pixel
- pix_x  out  $clog2(FRAME_WIDTH)  column of pix_data
- pix_y  out  $clog2(FRAME_HEIGHT)  row of pix_data
- pix_sof / pix_eol / pix_eof  out  1  first pixel of frame / last of row / last of frame
- pix_valid  out  1  output word valid
- pix_ready  in  1  downstream accepts when pix_valid && pix_ready
- frame_done  out  1  one-cycle pulse on accepted frame-end word
- proto_err  out  1  one-cycle pulse per protocol violation
- err_count  out  8  saturating violation count (stays 255)

## Operation
- Word encoding: bit16=0 → pixel in [15:0]; 17'h10000 FRAME_START; 17'h10001 ROW_START; 17'h1FFFF FRAME_END; any other bit16=1 word is illegal.
- Parser FSM, evaluated on each arriving word (cycle after pop): WAIT_FRAME, WAIT_ROW, ROW_PIXELS, WAIT_END.
- WAIT_FRAME: FRAME_START → WAIT_ROW, y=0. Every other word discarded silently (no error; resync mode).
- WAIT_ROW: ROW_START → ROW_PIXELS, x=0. Anything else → error.
- ROW_PIXELS: pixel → pushed into skid buffer with x,y,flags; x==FRAME_WIDTH-1 → WAIT_END if y==FRAME_HEIGHT-1 else WAIT_ROW with y+1. Command word → error (short row).
- WAIT_END: FRAME_END → frame_done, WAIT_FRAME. Anything else → error.
- FRAME_START in any state other than WAIT_FRAME: error, then treated as a valid frame start (→ WAIT_ROW, y=0).
- Any other error: proto_err pulse, err_count+1 (saturating), → WAIT_FRAME. Pixels already in the skid buffer are still delivered.
- Flags: pix_sof at x=0,y=0; pix_eol at x=FRAME_WIDTH-1; pix_eof at eol and y=FRAME_HEIGHT-1.
- Commands never reach the pixel output.

## Timing
- Reset values: queue_rd_en=0, pix_valid=0, pix_data/pix_x/pix_y=0, all flags 0, frame_done=0, proto_err=0, err_count=0, state WAIT_FRAME, buffer empty, in-flight flag 0.
- Skid buffer depth 3. queue_rd_en registered: high iff occupancy + in_flight < 3 (registered values only; no pix_ready→queue_rd_en path).
- Latency: pop at cycle N → word parsed N+1 → pix_valid earliest N+2.
- Sustained 1 pixel/clk with pix_ready held high and queue non-empty.
- pix_valid held, outputs stable while !pix_ready; buffer never overflows (guaranteed by the pop rule).
- Pop while empty: no word arrives; in-flight flag not set.
- Simultaneous push and pop on buffer: occupancy unchanged.
- frame_done/proto_err are single-cycle registered pulses, issued the cycle after the word arrives.
- Reset mid-frame: everything clears immediately; an in-flight queue word is discarded.

## Structure
- Shared package lcd_stream_pkg: the three command constants, word width (17), parser state enum. The debug-pattern and camera writers import the same constants.
- Sub-module pixel_skid_fifo (3-entry, width 16+x+y+3 flags, registered count) instantiated once; parser FSM and pop control in the top.

## Test plan
- Full frame, ready=1: FRAME_START, 272×(ROW_START + 480 pixels), FRAME_END → 130560 pixels in order, pix_sof only on first, 272 pix_eol, one pix_eof at (479,271), one frame_done, err_count=0.
- Backpressure: random 50% pix_ready, queue always non-empty → no pixel lost/duplicated, pix_data stable while stalled.
- Short row: ROW_START, 100 pixels, ROW_START → proto_err once, err_count=1, subsequent words dropped until next FRAME_START; next clean frame received correctly.
- Illegal command 17'h10005 in WAIT_ROW → proto_err, resync; stray pixels before FRAME_START produce no error.
- Mid-frame FRAME_START at row 10 → err_count+1, new frame starts at y=0 and completes with frame_done.
- Reset asserted mid-row with pix_ready=0 → all outputs zero within the reset; after release first delivered pixel is sof of the next frame.
